// File: rtl/mips_prog_loader.sv
// -----------------------------------------------------------------------------
// mips_prog_loader
//
// Host-side session controller for the two-phase pipelined MIPS32 core.
// One session is: load a program image into core memory from a host word
// stream, pulse the core's init, let the core run until it halts (or a cycle
// budget expires), then stream the first DUMP_N general-purpose registers
// back to the host and pulse done.
//
// Parameters
//   ADDR_W   memory word-address width
//   DUMP_N   registers dumped (R0..R(DUMP_N-1)), 1..32
//   TIMEOUT  maximum RUN cycles before a forced exit, >= 1
//
// Ports
//   clk1                    sole clock, rising edge
//   rst_n                   synchronous active-low reset
//   start, load_len         session request and number of words to load
//   in_valid/in_ready/in_data      program word stream from the host
//   mem_we/mem_addr/mem_wdata      core memory write port
//   cpu_init                one-cycle core init pulse (PC/HALTED/TAKEN_BRANCH)
//   cpu_run                 core enable while running
//   cpu_halted              core HALTED flag
//   reg_raddr/reg_rdata     core register read port (combinational read)
//   out_valid/out_ready/out_data   register dump stream to the host
//   busy                    session in progress
//   timeout                 sticky: last RUN ended on the cycle budget
//   done                    one-cycle pulse at session end
// -----------------------------------------------------------------------------
module mips_prog_loader #(
   parameter int ADDR_W  = 10,
   parameter int DUMP_N  = 6,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_init,
   output logic              cpu_run,
   input  logic              cpu_halted,
   output logic [4:0]        reg_raddr,
   input  logic [31:0]       reg_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              busy,
   output logic              timeout,
   output logic              done
);

   // Run counter is wide enough to hold TIMEOUT itself, so it never wraps
   // before the budget compare fires.
   localparam int RC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [RC_W-1:0] RC_LAST   = RC_W'(TIMEOUT - 1);
   localparam logic [4:0]      RIDX_LAST = 5'(DUMP_N - 1);
   localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0] LEN_ZERO  = (ADDR_W + 1)'(0);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_INIT = 3'd2,
      S_RUN  = 3'd3,
      S_RD   = 3'd4,
      S_SEND = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t            state_r;
   logic [ADDR_W:0]   len_r;      // latched load length
   logic [ADDR_W:0]   widx_r;     // next memory word to write
   logic [RC_W-1:0]   rc_r;       // RUN cycles elapsed
   logic [4:0]        ridx_r;     // register currently being dumped
   logic [31:0]       out_data_r; // captured register value
   logic              timeout_r;

   // Session sequencer: state, indices, captured dump word and timeout flag.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         len_r      <= LEN_ZERO;
         widx_r     <= LEN_ZERO;
         rc_r       <= {RC_W{1'b0}};
         ridx_r     <= 5'd0;
         out_data_r <= 32'h0000_0000;
         timeout_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  len_r     <= load_len;
                  timeout_r <= 1'b0;
                  widx_r    <= LEN_ZERO;
                  // An empty image skips straight to core init.
                  if (load_len == LEN_ZERO) begin
                     state_r <= S_INIT;
                  end else begin
                     state_r <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               // in_ready is constantly high here, so in_valid alone is
               // the handshake.
               if (in_valid) begin
                  widx_r <= widx_r + LEN_ONE;
                  if (widx_r == len_r - LEN_ONE) begin
                     state_r <= S_INIT;
                  end
               end
            end
            S_INIT: begin
               rc_r    <= {RC_W{1'b0}};
               state_r <= S_RUN;
            end
            S_RUN: begin
               rc_r <= rc_r + RC_W'(1);
               // Halt takes priority: a halt on the last budget cycle is a
               // normal completion, not a timeout.
               if (cpu_halted) begin
                  ridx_r  <= 5'd0;
                  state_r <= S_RD;
               end else if (rc_r == RC_LAST) begin
                  ridx_r    <= 5'd0;
                  timeout_r <= 1'b1;
                  state_r   <= S_RD;
               end
            end
            S_RD: begin
               out_data_r <= reg_rdata;
               state_r    <= S_SEND;
            end
            S_SEND: begin
               if (out_ready) begin
                  if (ridx_r == RIDX_LAST) begin
                     state_r <= S_DONE;
                  end else begin
                     ridx_r  <= ridx_r + 5'd1;
                     state_r <= S_RD;
                  end
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // Output decode from the registered state; the memory write port follows
   // the input handshake within the same cycle.
   always_comb begin
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = 32'h0000_0000;
      cpu_init  = 1'b0;
      cpu_run   = 1'b0;
      reg_raddr = 5'd0;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_r)
         S_IDLE: begin
            busy = 1'b0;
         end
         S_LOAD: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid) begin
               mem_we    = 1'b1;
               mem_addr  = widx_r[ADDR_W-1:0];
               mem_wdata = in_data;
            end else begin
               mem_we    = 1'b0;
            end
         end
         S_INIT: begin
            busy     = 1'b1;
            cpu_init = 1'b1;
         end
         S_RUN: begin
            busy    = 1'b1;
            cpu_run = 1'b1;
         end
         S_RD: begin
            busy      = 1'b1;
            reg_raddr = ridx_r;
         end
         S_SEND: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign out_data = out_data_r;
   assign timeout  = timeout_r;

endmodule

// File: tb/tb_mips_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_mips_prog_loader
//
// Directed bench for mips_prog_loader. A small behavioural core stands in for
// the MIPS32 core: one instruction per cpu_run cycle out of the memory the
// loader writes (ADD, OR, ADDI, HLT), with a combinational register read port.
// -----------------------------------------------------------------------------
module tb_mips_prog_loader;

   logic        clk1;
   logic        rst_n;
   logic        start;
   logic [10:0] load_len;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_init;
   logic        cpu_run;
   logic        cpu_halted;
   logic [4:0]  reg_raddr;
   logic [31:0] reg_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;
   logic        timeout;
   logic        done;

   int tests = 0;
   int fails = 0;

   mips_prog_loader #(.ADDR_W(10), .DUMP_N(6), .TIMEOUT(16)) dut (
      .clk1(clk1), .rst_n(rst_n), .start(start), .load_len(load_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_init(cpu_init), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
      .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .timeout(timeout), .done(done)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   // Program image and its expected register results.
   logic [31:0] prog [0:8] = '{32'h2801000a, 32'h28020014, 32'h28030019,
                               32'h0ce77800, 32'h0ce77800, 32'h00222000,
                               32'h0ce77800, 32'h00832800, 32'hfc000000};
   logic [31:0] expr [0:5] = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};

   // ---------------- behavioural core + observation counters ----------------
   logic [31:0] imem [0:1023];
   logic [31:0] gpr  [0:31];
   logic [9:0]  pc    = 10'd0;
   logic        mhalt = 1'b0;
   logic        tie0;
   logic [31:0] ins;
   logic [4:0]  f_rs, f_rt, f_rd;

   logic [9:0]  wlog_a [0:63];
   logic [31:0] wlog_d [0:63];
   int wr_total = 0;
   int init_cnt = 0;
   int run_cnt  = 0;
   int rdy_cnt  = 0;
   int done_cnt = 0;

   assign cpu_halted = mhalt & ~tie0;
   assign reg_rdata  = gpr[reg_raddr];
   assign ins  = imem[pc];
   assign f_rs = ins[25:21];
   assign f_rt = ins[20:16];
   assign f_rd = ins[15:11];

   always @(posedge clk1) begin
      if (mem_we) begin
         imem[mem_addr]   <= mem_wdata;
         wlog_a[wr_total] <= mem_addr;
         wlog_d[wr_total] <= mem_wdata;
         wr_total         <= wr_total + 1;
      end
      if (cpu_run)  run_cnt  <= run_cnt + 1;
      if (in_ready) rdy_cnt  <= rdy_cnt + 1;
      if (done)     done_cnt <= done_cnt + 1;
      if (!rst_n) begin
         pc    <= 10'd0;
         mhalt <= 1'b0;
         for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
      end else if (cpu_init) begin
         pc       <= 10'd0;
         mhalt    <= 1'b0;
         init_cnt <= init_cnt + 1;
      end else if (cpu_run && !mhalt) begin
         case (ins[31:26])
            6'h00: gpr[f_rd] <= gpr[f_rs] + gpr[f_rt];
            6'h03: gpr[f_rd] <= gpr[f_rs] | gpr[f_rt];
            6'h0a: gpr[f_rt] <= gpr[f_rs] + {{16{ins[15]}}, ins[15:0]};
            6'h3f: mhalt <= 1'b1;
            default: ;
         endcase
         pc <= pc + 10'd1;
      end
   end

   // ------------------------------- helpers ---------------------------------
   task automatic tick;
      @(posedge clk1);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {24'd0, in_ready, mem_we, cpu_init, cpu_run,
                          out_valid, busy, timeout, done}, 32'd0);
      chk({tag, "_dat"}, out_data, 32'd0);
      chk({tag, "_adr"}, {17'd0, reg_raddr, mem_addr}, 32'd0);
      chk({tag, "_wd"},  mem_wdata, 32'd0);
   endtask

   task automatic do_start(input logic [10:0] len);
      load_len = len;
      start    = 1'b1;
      tick;
      start    = 1'b0;
   endtask

   task automatic feed(input int n, input bit gap);
      int w;
      for (int i = 0; i < n; i++) begin
         if (gap) begin
            in_valid = 1'b0;
            in_data  = 32'hdead_beef;
            #1;
            chk("gap_no_we", {31'd0, mem_we}, 32'd1 - 32'd1);
            tick;
         end
         in_valid = 1'b1;
         in_data  = prog[i];
         w = 0;
         while (!in_ready && w < 20) begin
            tick;
            w++;
         end
         if (gap) begin
            #1;
            chk("hs_we", {31'd0, mem_we}, 32'd1);
         end
         tick;
      end
      in_valid = 1'b0;
   endtask

   // Checks the write log entries [base, wr_total) against addresses 0.. and prog.
   task automatic chk_log(input string tag, input int base, input int n);
      int err;
      err = 0;
      for (int k = 0; k < n; k++) begin
         if (wlog_a[base + k] !== 10'(k) || wlog_d[base + k] !== prog[k]) err++;
      end
      chk({tag, "_wcount"}, 32'(wr_total - base), 32'(n));
      chk({tag, "_worder"}, 32'(err), 32'd0);
   endtask

   task automatic wait_ov(input string tag);
      int w;
      w = 0;
      while (!out_valid && w < 100) begin
         tick;
         w++;
      end
      chk(tag, {31'd0, out_valid}, 32'd1);
   endtask

   // Receives the whole dump; stall_word >= 0 holds out_ready low for 5 cycles.
   task automatic dump_all(input string tag, input int stall_word);
      logic [31:0] held;
      for (int i = 0; i < 6; i++) begin
         wait_ov({tag, "_ov"});
         if (i == stall_word) begin
            out_ready = 1'b0;
            held = out_data;
            for (int s = 0; s < 5; s++) begin
               tick;
               chk({tag, "_stall_v"}, {31'd0, out_valid}, 32'd1);
               chk({tag, "_stall_d"}, out_data, held);
            end
            out_ready = 1'b1;
         end
         chk($sformatf("%s_r%0d", tag, i), out_data, expr[i]);
         tick;
      end
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      tick;
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   // ------------------------------ stimulus ---------------------------------
   int b_wr, b_init, b_run, b_rdy, b_done;

   initial begin
      rst_n = 1'b0; start = 1'b0; load_len = 11'd0; in_valid = 1'b0;
      in_data = 32'd0; out_ready = 1'b1; tie0 = 1'b0;
      tick;
      tick;
      chk_zero("reset");
      rst_n = 1'b1;
      tick;

      // Session 1: full program, normal halt.
      b_wr = wr_total; b_init = init_cnt; b_run = run_cnt; b_done = done_cnt;
      do_start(11'd9);
      chk("s1_busy", {31'd0, busy}, 32'd1);
      chk("s1_ready", {31'd0, in_ready}, 32'd1);
      feed(9, 1'b0);
      chk("s1_init", {31'd0, cpu_init}, 32'd1);
      dump_all("s1", -1);
      chk_log("s1", b_wr, 9);
      chk("s1_inits", 32'(init_cnt - b_init), 32'd1);
      chk("s1_runs", 32'(run_cnt - b_run), 32'd10);
      chk("s1_dones", 32'(done_cnt - b_done), 32'd1);
      chk("s1_timeout", {31'd0, timeout}, 32'd0);

      // Session 2: empty load, halt masked -> timeout after 16 RUN cycles.
      tie0 = 1'b1;
      b_run = run_cnt; b_rdy = rdy_cnt;
      do_start(11'd0);
      chk("s2_init_direct", {31'd0, cpu_init}, 32'd1);
      dump_all("s2", -1);
      chk("s2_runs", 32'(run_cnt - b_run), 32'd16);
      chk("s2_timeout", {31'd0, timeout}, 32'd1);
      chk("s2_no_ready", 32'(rdy_cnt - b_rdy), 32'd0);

      // Session 3: next start clears timeout; gapped load; stalled dump.
      tie0 = 1'b0;
      b_wr = wr_total;
      do_start(11'd9);
      chk("s3_timeout_clr", {31'd0, timeout}, 32'd0);
      feed(9, 1'b1);
      dump_all("s3", 2);
      chk_log("s3", b_wr, 9);
      chk("s3_timeout", {31'd0, timeout}, 32'd0);

      // Session 4: start ignored mid-RUN, then reset mid-RUN.
      tie0 = 1'b1;
      do_start(11'd0);
      tick;
      tick;
      chk("s4_run", {31'd0, cpu_run}, 32'd1);
      do_start(11'd5);
      chk("s4_start_ign", {30'd0, cpu_run, in_ready}, 32'd2);
      rst_n = 1'b0;
      tick;
      chk_zero("s4_rst");
      rst_n = 1'b1;
      tick;
      chk("s4_stay_idle", {31'd0, busy}, 32'd0);

      // Session 5: reset while SEND is stalled.
      tie0 = 1'b0;
      do_start(11'd0);
      wait_ov("s5_ov");
      out_ready = 1'b0;
      tick;
      chk("s5_send", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      tick;
      chk_zero("s5_rst");
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick;
      chk_zero("s5_idle");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Host-side program loader and result reader for the two-phase pipelined MIPS32 core. It streams a program image into instruction/data memory and initialises the core. It then runs the core until `HLT` or a timeout, and streams the first `DUMP_N` general-purpose registers back to the host. It replaces hierarchical testbench pokes and peeks with a synthesizable session controller sitting between a host word stream and the core's memory write port and register read port.

## Interface
- `ADDR_W`, 10: memory word-address width.
- `DUMP_N`, 6: number of registers read back (R0..R`DUMP_N`-1), range 1..32.
- `TIMEOUT`, 1024: maximum RUN cycles before forced exit, ≥1.
- `clk1`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begins a session; honoured only in IDLE.
- `load_len`  in  ADDR_W+1  number of words to load; sampled when `start` is accepted.
- `in_valid` / `in_ready` / `in_data`  in / out / in  1/1/32  program word stream.
- `mem_we` / `mem_addr` / `mem_wdata`  out  1/ADDR_W/32  memory write port.
- `cpu_init`  out  1  one-cycle pulse: core clears PC, HALTED, TAKEN_BRANCH.
- `cpu_run`  out  1  core enable, high throughout RUN.
- `cpu_halted`  in  1  core HALTED flag.
- `reg_raddr` / `reg_rdata`  out / in  5/32  register read port; combinational read.
- `out_valid` / `out_ready` / `out_data`  out / in / out  1/1/32  register dump stream.
- `busy`  out  1  high in every state except IDLE.
- `timeout`  out  1  sticky; set if RUN ended by TIMEOUT; cleared on accepted `start`.
- `done`  out  1  one-cycle pulse at session end.

## Operation
- States: IDLE, LOAD, INIT, RUN, RD, SEND, DONE.
- IDLE: `start`=1 latches `load_len`, clears `timeout`, word index `widx`=0, then goes to LOAD. If `load_len`=0 it goes to INIT instead.
- LOAD: `in_ready`=1. Each handshake (`in_valid`&&`in_ready`) drives `mem_we`=1, `mem_addr`=`widx`[ADDR_W-1:0], `mem_wdata`=`in_data` combinationally in that cycle, and `widx`++. The handshake with `widx`=`load_len`-1 moves to INIT. `in_valid` low stalls with no write.
- INIT: exactly one cycle; `cpu_init`=1; RUN cycle counter `rc` cleared; then RUN.
- RUN: `cpu_run`=1; `rc`++ each cycle. Exit to RD when `cpu_halted`=1 is sampled, or when `rc`=`TIMEOUT`-1. The timeout exit sets `timeout`. If both conditions hold in the same cycle, halt wins and `timeout` stays 0. The dump index `ridx` is cleared on exit.
- RD: `reg_raddr`=`ridx`; `reg_rdata` captured into `out_data`; then SEND.
- SEND: `out_valid`=1; `out_data` stable until `out_ready`. On handshake, if `ridx`=`DUMP_N`-1 go to DONE; otherwise `ridx`++ and go to RD.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. `in_valid` outside LOAD is ignored, with no write and `in_ready`=0.
- Reset (any state, mid-load or mid-dump included): state=IDLE. Outputs reset to 0: `in_ready`, `mem_we`, `cpu_init`, `cpu_run`, `out_valid`, `out_data`, `busy`, `timeout`, `done`, `reg_raddr`, `mem_addr`, `mem_wdata`. Partially written memory is not restored.

## Timing
- `mem_we`, `in_ready`, `cpu_run`, `cpu_init`, `out_valid`, `busy`, `done` are decoded from the registered state. `mem_addr`/`mem_wdata` follow the input handshake in the same cycle.
- Minimum session length: L load cycles + 1 INIT cycle + R run cycles + 2·DUMP_N dump cycles (with `out_ready` held 1) + 1 DONE cycle.
- `widx` and `rc` have enough width that `load_len`=2^ADDR_W and `TIMEOUT` do not wrap.
- `cpu_halted` already high on the first RUN cycle: RUN lasts exactly one cycle.
- The dump delivers one word per 2 cycles at best. `out_ready` low holds SEND indefinitely.

## Test plan
- Reset then load 9 words (0x2801000a, 0x28020014, 0x28030019, 0x0ce77800, 0x0ce77800, 0x00222000, 0x0ce77800, 0x00832800, 0xfc000000) with a real core attached -> writes to addresses 0..8 in order; one `cpu_init` pulse; `cpu_halted` rises. Dump shows R0=0, R1=10, R2=20, R3=25, R4=30, R5=55, then a `done` pulse, with `timeout`=0.
- Load with `in_valid` toggling every other cycle -> `mem_we` only on handshake cycles, consecutive addresses, no gaps or duplicates.
- `cpu_halted` tied 0, `TIMEOUT`=16 -> `cpu_run` high exactly 16 cycles; `timeout`=1; dump still completes. The next `start` clears `timeout`.
- `load_len`=0 -> IDLE→INIT directly; `in_ready` never asserts.
- `out_ready` low for 5 cycles on word 2 -> `out_valid`=1 and `out_data` stable throughout; `ridx` does not advance.
- `rst_n`=0 for one cycle mid-RUN, and separately mid-SEND -> all outputs 0 next cycle, state IDLE. A `start` pulse during an active session is ignored.
